// File: rtl/ili_spi_tx_if.sv
//------------------------------------------------------------------------------
// ili_spi_tx_if
//   Request/status interface between a panel controller and ili_spi_tx.
//
//   Signals
//     i_send_ena : transfer request, sampled every clock
//     i_dc       : 0 = command word, 1 = parameter/data word
//     i_data     : word to shift out, MSB first
//     o_busy     : transmitter is working on a word
//     o_sent     : one-cycle completion pulse
//
//   Modports
//     master : controller side (drives the request)
//     slave  : transmitter side (drives busy/sent)
//------------------------------------------------------------------------------
interface ili_spi_tx_if #(
    parameter int DW = 8
);
    logic          i_send_ena;
    logic          i_dc;
    logic [DW-1:0] i_data;
    logic          o_busy;
    logic          o_sent;

    modport master (
        output i_send_ena,
        output i_dc,
        output i_data,
        input  o_busy,
        input  o_sent
    );

    modport slave (
        input  i_send_ena,
        input  i_dc,
        input  i_data,
        output o_busy,
        output o_sent
    );
endinterface

// File: rtl/ili_spi_tx.sv
//------------------------------------------------------------------------------
// ili_spi_tx
//   Write-only SPI (mode 0) serializer for ILI-style display panels. A request
//   latches one DW-bit word plus its D/CX flag, then the word is shifted out
//   MSB first with chip select asserted around it.
//
//   Parameters
//     DW      : serial word width in bits (1..32)
//     CLK_DIV : clk cycles per SCL half-period (>= 1)
//
//   Ports
//     clk, rst    : single clock, synchronous active-high reset
//     bus (slave) : i_send_ena / i_dc / i_data request, o_busy / o_sent status
//     o_spi_cs_n  : panel chip select, active low
//     o_spi_dc    : panel D/CX, holds its last value while idle
//     o_spi_scl   : serial clock, idle low
//     o_spi_sda   : serial data, MSB first, 0 while idle
//
//   Build option
//     ILI_SPI_BURST_EN : when defined, a request seen in DONE is accepted and
//                        chip select stays low between consecutive words.
//
//   Timing: accepted in cycle 0 -> SETUP for CLK_DIV cycles, SHIFT for
//   2*DW*CLK_DIV cycles, HOLD for CLK_DIV cycles, DONE (o_sent) in cycle
//   1 + 2*CLK_DIV + 2*DW*CLK_DIV.
//------------------------------------------------------------------------------
module ili_spi_tx #(
    parameter int DW      = 8,
    parameter int CLK_DIV = 2
) (
    input  logic        clk,
    input  logic        rst,
    ili_spi_tx_if.slave bus,
    output logic        o_spi_cs_n,
    output logic        o_spi_dc,
    output logic        o_spi_scl,
    output logic        o_spi_sda
);

    localparam int DIVW = $clog2(CLK_DIV) + 1;
    localparam int BITW = $clog2(DW) + 1;

    localparam logic [DIVW-1:0] DIV_LAST = DIVW'(CLK_DIV - 1);
    localparam logic [BITW-1:0] BIT_LAST = BITW'(DW);

`ifdef ILI_SPI_BURST_EN
    // Chip select is kept low in DONE so the next word can follow directly.
    localparam logic CS_IN_DONE = 1'b0;
`else
    localparam logic CS_IN_DONE = 1'b1;
`endif

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        DONE
    } state_t;

    state_t          r_state,   w_state_nxt;
    logic [DIVW-1:0] r_div_cnt, w_div_cnt_nxt;
    logic [BITW-1:0] r_bit_cnt, w_bit_cnt_nxt;
    logic [DW-1:0]   r_shreg,   w_shreg_nxt;
    logic            r_dc,      w_dc_nxt;
    logic            r_scl,     w_scl_nxt;
    logic            r_cs_n,    w_cs_n_nxt;
    logic            r_busy,    w_busy_nxt;
    logic            r_sent,    w_sent_nxt;

    logic            w_div_done;
    logic            w_accept;

    // Last cycle of the current SCL half-period (or SETUP/HOLD window).
    assign w_div_done = (r_div_cnt == DIV_LAST);

    // Requests are only looked at when no word is in flight; busy cycles
    // simply never reach the latch below.
`ifdef ILI_SPI_BURST_EN
    assign w_accept = bus.i_send_ena && ((r_state == IDLE) || (r_state == DONE));
`else
    assign w_accept = bus.i_send_ena && (r_state == IDLE);
`endif

    //--------------------------------------------------------------------------
    // Next-state and next-output logic. Every output is a flop loaded from the
    // next-state values, so the pins line up with the state they belong to and
    // no input reaches a pin combinationally.
    //--------------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        w_div_cnt_nxt = r_div_cnt;
        w_bit_cnt_nxt = r_bit_cnt;
        w_shreg_nxt   = r_shreg;
        w_dc_nxt      = r_dc;
        w_scl_nxt     = r_scl;

        case (r_state)
            IDLE: begin
                w_scl_nxt = 1'b0;
            end

            SETUP: begin
                if (w_div_done) begin
                    w_state_nxt   = SHIFT;
                    w_div_cnt_nxt = '0;
                    w_scl_nxt     = 1'b1;   // first rising edge, MSB already on sda
                end else begin
                    w_div_cnt_nxt = r_div_cnt + 1'b1;
                end
            end

            SHIFT: begin
                if (w_div_done) begin
                    w_div_cnt_nxt = '0;
                    if (r_scl) begin
                        // Falling edge: present the next bit and count this one.
                        w_scl_nxt     = 1'b0;
                        w_shreg_nxt   = r_shreg << 1;
                        w_bit_cnt_nxt = r_bit_cnt + 1'b1;
                    end else if (r_bit_cnt == BIT_LAST) begin
                        // Low phase after the last falling edge has elapsed.
                        w_state_nxt = HOLD;
                    end else begin
                        w_scl_nxt = 1'b1;
                    end
                end else begin
                    w_div_cnt_nxt = r_div_cnt + 1'b1;
                end
            end

            HOLD: begin
                if (w_div_done) begin
                    w_state_nxt   = DONE;
                    w_div_cnt_nxt = '0;
                end else begin
                    w_div_cnt_nxt = r_div_cnt + 1'b1;
                end
            end

            DONE: begin
                w_state_nxt = IDLE;
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        // Acceptance overrides the normal progression (IDLE, or DONE in burst).
        if (w_accept) begin
            w_state_nxt   = SETUP;
            w_div_cnt_nxt = '0;
            w_bit_cnt_nxt = '0;
            w_shreg_nxt   = bus.i_data;
            w_dc_nxt      = bus.i_dc;
            w_scl_nxt     = 1'b0;
        end

        w_busy_nxt = (w_state_nxt != IDLE);
        w_sent_nxt = (w_state_nxt == DONE);
        w_cs_n_nxt = (w_state_nxt == IDLE) || ((w_state_nxt == DONE) && CS_IN_DONE);
    end

    //--------------------------------------------------------------------------
    // State and output registers
    //--------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_div_cnt <= '0;
            r_bit_cnt <= '0;
            r_shreg   <= '0;
            r_dc      <= 1'b0;
            r_scl     <= 1'b0;
            r_cs_n    <= 1'b1;
            r_busy    <= 1'b0;
            r_sent    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_div_cnt <= w_div_cnt_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_shreg   <= w_shreg_nxt;
            r_dc      <= w_dc_nxt;
            r_scl     <= w_scl_nxt;
            r_cs_n    <= w_cs_n_nxt;
            r_busy    <= w_busy_nxt;
            r_sent    <= w_sent_nxt;
        end
    end

    // The shifter fills with zeros, so after a full word (or reset) the MSB,
    // and therefore sda, is 0 while idle.
    assign o_spi_sda  = r_shreg[DW-1];
    assign o_spi_scl  = r_scl;
    assign o_spi_cs_n = r_cs_n;
    assign o_spi_dc   = r_dc;
    assign bus.o_busy = r_busy;
    assign bus.o_sent = r_sent;

endmodule

// File: tb/tb_ili_spi_tx.sv
module tb_ili_spi_tx;
    localparam int DW = 8;
`ifdef ILI_SPI_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic ena;
    logic dcin;
    logic [7:0] din;
    always #5 clk = ~clk;

    ili_spi_tx_if #(.DW(DW)) bus0 ();
    ili_spi_tx_if #(.DW(DW)) bus1 ();
    assign bus0.i_send_ena = ena;
    assign bus0.i_dc       = dcin;
    assign bus0.i_data     = din;
    assign bus1.i_send_ena = ena;
    assign bus1.i_dc       = dcin;
    assign bus1.i_data     = din;

    logic cs_n0, dc0, scl0, sda0;
    logic cs_n1, dc1, scl1, sda1;

    ili_spi_tx #(.DW(DW), .CLK_DIV(2)) u_dut0 (
        .clk(clk), .rst(rst), .bus(bus0),
        .o_spi_cs_n(cs_n0), .o_spi_dc(dc0), .o_spi_scl(scl0), .o_spi_sda(sda0)
    );
    ili_spi_tx #(.DW(DW), .CLK_DIV(1)) u_dut1 (
        .clk(clk), .rst(rst), .bus(bus1),
        .o_spi_cs_n(cs_n1), .o_spi_dc(dc1), .o_spi_scl(scl1), .o_spi_sda(sda1)
    );

    typedef struct {
        logic [7:0] data;
        logic       dc;
        int         lat0;
        int         lat1;
    } vec_t;

    int n_checks, n_errs, cyc;

    // reference model state, one per DUT
    bit         m_ready;
    bit         m_act [2];
    int         m_k   [2];
    logic [7:0] m_data[2];
    logic       m_dc  [2];

    // observation bookkeeping
    int          sent_cnt[2], sent_last[2], sent_prev[2];
    logic        csn_at_sent[2];
    logic [31:0] cap[2];
    int          nbits[2];
    logic        prev_scl[2];
    int          csn_hi0, snap_last, snap_prev;
    int          rise_last1, rise_prev1;

    function automatic int dlat(input int div);
        return 1 + 2*div + 2*DW*div;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", nm, cyc, got, exp);
        end
    endtask

    task automatic monitor();
        for (int di = 0; di < 2; di++) begin
            int   div = (di == 0) ? 2 : 1;
            int   dd  = dlat(div);
            logic cs_n, scl, sda, busy, sent, dcv;
            logic e_cs_n, e_scl, e_sda, e_busy, e_sent;
            bit   sda_chk;
            if (di == 0) begin
                cs_n = cs_n0; scl = scl0; sda = sda0; dcv = dc0;
                busy = bus0.o_busy; sent = bus0.o_sent;
            end else begin
                cs_n = cs_n1; scl = scl1; sda = sda1; dcv = dc1;
                busy = bus1.o_busy; sent = bus1.o_sent;
            end
            if (m_ready) begin
                e_cs_n = 1'b1; e_scl = 1'b0; e_sda = 1'b0; e_busy = 1'b0; e_sent = 1'b0;
                sda_chk = 1'b1;
                if (m_act[di]) begin
                    int k = m_k[di];
                    e_busy  = 1'b1;
                    e_sent  = (k == dd);
                    e_cs_n  = (k == dd) ? !BURST : 1'b0;
                    sda_chk = 1'b0;
                    if (k <= div) begin
                        e_sda = m_data[di][DW-1]; sda_chk = 1'b1;
                    end else if (k <= div + 2*DW*div) begin
                        int half = (k - 1 - div) / div;
                        int b    = (half + 1) / 2;
                        e_scl = (half % 2 == 0);
                        if (b < DW) begin
                            e_sda = m_data[di][DW-1-b]; sda_chk = 1'b1;
                        end
                    end
                end
                chk($sformatf("pins%0d{cs_n,scl,busy,sent,dc}", di),
                    32'({cs_n, scl, busy, sent, dcv}),
                    32'({e_cs_n, e_scl, e_busy, e_sent, m_dc[di]}));
                if (sda_chk) chk($sformatf("sda%0d", di), 32'(sda), 32'(e_sda));
            end
            // observations
            if (di == 0 && cs_n === 1'b1) csn_hi0++;
            if (sent === 1'b1) begin
                sent_cnt[di]++;
                sent_prev[di]   = sent_last[di];
                sent_last[di]   = cyc;
                csn_at_sent[di] = cs_n;
                if (di == 0) begin snap_prev = snap_last; snap_last = csn_hi0; end
            end
            if (scl === 1'b1 && prev_scl[di] === 1'b0) begin
                cap[di] = {cap[di][30:0], sda};
                nbits[di]++;
                if (di == 1) begin rise_prev1 = rise_last1; rise_last1 = cyc; end
            end
            prev_scl[di] = scl;
            // model advance on the coming edge
            if (rst) begin
                m_act[di] = 1'b0; m_k[di] = 0; m_dc[di] = 1'b0;
            end else if (m_act[di] && m_k[di] == dd) begin
                if (BURST && ena) begin
                    m_k[di] = 1; m_data[di] = din; m_dc[di] = dcin;
                end else begin
                    m_act[di] = 1'b0;
                end
            end else if (m_act[di]) begin
                m_k[di]++;
            end else if (ena) begin
                m_act[di] = 1'b1; m_k[di] = 1; m_data[di] = din; m_dc[di] = dcin;
            end
        end
        if (rst) m_ready = 1'b1;
    endtask

    task automatic step();
        @(negedge clk);
        monitor();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic chk_reset(input string nm);
        chk({nm, "0"}, 32'({cs_n0, scl0, sda0, bus0.o_busy, bus0.o_sent, dc0}), 32'b100000);
        chk({nm, "1"}, 32'({cs_n1, scl1, sda1, bus1.o_busy, bus1.o_sent, dc1}), 32'b100000);
    endtask

    task automatic wait_sent(input int di, input int target);
        int bud = 0;
        while (sent_cnt[di] < target && bud < 300) begin
            din = 8'($urandom); dcin = 1'($urandom); step(); bud++;
        end
        chk($sformatf("sent_timeout%0d", di), 32'(bud < 300), 32'd1);
    endtask

    task automatic xfer(input logic [7:0] d, input logic dcv, input int lat0, input int lat1);
        int t0, s0, s1, b0, b1;
        s0 = sent_cnt[0]; s1 = sent_cnt[1]; b0 = nbits[0]; b1 = nbits[1];
        ena = 1'b1; din = d; dcin = dcv; t0 = cyc;
        step();
        ena = 1'b0;
        wait_sent(1, s1 + 1);
        wait_sent(0, s0 + 1);
        chk("lat0", sent_last[0] - t0, lat0);
        chk("lat1", sent_last[1] - t0, lat1);
        chk("word0", 32'(cap[0][7:0]), 32'(d));
        chk("word1", 32'(cap[1][7:0]), 32'(d));
        chk("nbits0", nbits[0] - b0, 8);
        chk("nbits1", nbits[1] - b1, 8);
        chk("npulse0", sent_cnt[0] - s0, 1);
        chk("npulse1", sent_cnt[1] - s1, 1);
        chk("csn_done0", 32'(csn_at_sent[0]), 32'(!BURST));
        chk("scl_period1", rise_last1 - rise_prev1, 2);
        din = 8'h00; dcin = 1'b0;
        repeat (3) step();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[6];
        int   t0, s0, s1, b0;
        tbl[0] = '{8'h2A, 1'b0, 37, 19};
        tbl[1] = '{8'hFF, 1'b1, 37, 19};
        tbl[2] = '{8'h00, 1'b0, 37, 19};
        tbl[3] = '{8'h81, 1'b1, 37, 19};
        tbl[4] = '{8'h55, 1'b0, 37, 19};
        tbl[5] = '{8'hA5, 1'b1, 37, 19};
        n_checks = 0; n_errs = 0; cyc = 0;
        csn_hi0 = 0; snap_last = 0; snap_prev = 0; rise_last1 = 0; rise_prev1 = 0;
        for (int i = 0; i < 2; i++) begin
            sent_cnt[i] = 0; sent_last[i] = 0; sent_prev[i] = 0; cap[i] = '0;
            nbits[i] = 0; prev_scl[i] = 1'b0; m_act[i] = 1'b0; m_k[i] = 0;
            m_data[i] = '0; m_dc[i] = 1'b0; csn_at_sent[i] = 1'b0;
        end
        m_ready = 1'b0;

        // reset held 3 cycles with a pending request
        rst = 1'b1; ena = 1'b1; din = 8'hFF; dcin = 1'b1;
        @(posedge clk); #1;
        chk_reset("rst_a");
        step(); chk_reset("rst_b");
        step(); chk_reset("rst_c");
        rst = 1'b0; ena = 1'b0; din = 8'h00; dcin = 1'b0;
        repeat (3) step();

        // table-driven single transfers
        for (int i = 0; i < 6; i++) xfer(tbl[i].data, tbl[i].dc, tbl[i].lat0, tbl[i].lat1);

        // second request while busy is ignored
        s0 = sent_cnt[0]; s1 = sent_cnt[1];
        ena = 1'b1; din = 8'hFF; dcin = 1'b1; t0 = cyc;
        step(); ena = 1'b0;
        while (cyc < t0 + 10) step();
        ena = 1'b1; din = 8'h55; dcin = 1'b0;
        step(); ena = 1'b0;
        wait_sent(0, s0 + 1);
        chk("busy_word0", 32'(cap[0][7:0]), 32'hFF);
        chk("busy_word1", 32'(cap[1][7:0]), 32'hFF);
        repeat (50) step();
        chk("busy_pulses0", sent_cnt[0] - s0, 1);
        chk("busy_pulses1", sent_cnt[1] - s1, 1);

        // reset mid-transfer aborts without o_sent
        s0 = sent_cnt[0]; s1 = sent_cnt[1];
        ena = 1'b1; din = 8'hA5; dcin = 1'b1; t0 = cyc;
        step(); ena = 1'b0;
        while (cyc < t0 + 15) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_reset("abort");
        repeat (60) step();
        chk("abort_pulses0", sent_cnt[0] - s0, 0);
        chk("abort_pulses1", sent_cnt[1] - s1, 0);
        xfer(8'h3C, 1'b0, 37, 19);

        // back-to-back: command 0x2C then data 0x12 with the request held
        s0 = sent_cnt[0]; b0 = nbits[0];
        ena = 1'b1; din = 8'h2C; dcin = 1'b0; t0 = cyc;
        step();
        din = 8'h12; dcin = 1'b1;
        while (cyc < t0 + 39) step();
        ena = 1'b0;
        wait_sent(0, s0 + 2);
        chk("b2b_pulses", sent_cnt[0] - s0, 2);
        chk("b2b_spacing", sent_last[0] - sent_prev[0], BURST ? 37 : 38);
        chk("b2b_csn_gap", snap_last - snap_prev, BURST ? 0 : 2);
        chk("b2b_words", 32'(cap[0][15:0]), 32'h2C12);
        chk("b2b_nbits", nbits[0] - b0, 16);
        repeat (60) step();

        // random traffic against the model
        for (int i = 0; i < 1500; i++) begin
            rst  = ($urandom_range(0, 199) == 0);
            ena  = ($urandom_range(0, 4) == 0);
            din  = 8'($urandom);
            dcin = 1'($urandom);
            step();
        end
        rst = 1'b0; ena = 1'b0;
        repeat (60) step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end
endmodule
